// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants and helpers for the pipeline register chain
package pipe_pkg;
    localparam int PIPE_LOCKSTEP = 0;
    localparam int PIPE_COLLAPSE = 1;

    function automatic int clog2_p1(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one valid+data pipeline register with hold, load and kill controls
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic             load,
    input  logic [WIDTH-1:0] src_data,
    input  logic             kill,
    output logic             valid,
    output logic [WIDTH-1:0] data
);
    logic             valid_d, valid_q;
    logic [WIDTH-1:0] data_d, data_q;

    // kill overrides valid only; data is written solely when a real item arrives
    always_comb begin
        valid_d = kill ? 1'b0 : (hold ? valid_q : load);
        data_d  = (!hold && load) ? src_data : data_q;
    end

    // slot register, cleared asynchronously by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
endmodule

// File: rtl/pipe_chain.sv
// pipe_chain: parametrised pipeline register chain with stall, flush and bubble collapsing
module pipe_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH           = 32,
    parameter int STAGES          = 4,
    parameter int BUBBLE_COLLAPSE = PIPE_COLLAPSE
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          in_ready,
    input  logic [STAGES-1:0]             stall_req,
    input  logic [STAGES-1:0]             flush_req,
    output logic                          out_valid,
    output logic [WIDTH-1:0]              out_data,
    input  logic                          out_ready,
    output logic [STAGES-1:0]             stage_valid,
    output logic [STAGES*WIDTH-1:0]       stage_data,
    output logic [clog2_p1(STAGES)-1:0]   count
);
    localparam int CW = clog2_p1(STAGES);

    logic [STAGES-1:0]       hold, kill, src_valid;
    logic [STAGES*WIDTH-1:0] src_data;
    int                      fl_top;

    assign src_valid = {stage_valid[STAGES-2:0] & ~hold[STAGES-2:0], in_valid};
    assign src_data  = {stage_data[(STAGES-1)*WIDTH-1:0], in_data};

    // hold ripples from the oldest slot down; flush kills everything whose next content comes from slot <= fl_top
    always_comb begin
        hold   = '0;
        kill   = '0;
        fl_top = 0;
        hold[STAGES-1] = stall_req[STAGES-1] | (stage_valid[STAGES-1] & ~out_ready);
        for (int k = STAGES - 2; k >= 0; k--)
            hold[k] = stall_req[k] | ((BUBBLE_COLLAPSE == PIPE_LOCKSTEP || stage_valid[k]) & hold[k+1]);
        for (int k = 0; k < STAGES; k++)
            if (flush_req[k]) fl_top = k;
        for (int k = 0; k < STAGES; k++)
            kill[k] = (|flush_req) && (k <= fl_top + (hold[k] ? 0 : 1));
    end

    // popcount of the registered valid bits
    always_comb begin
        count = '0;
        for (int k = 0; k < STAGES; k++)
            count = count + CW'(stage_valid[k]);
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_slot
        pipe_slot #(.WIDTH(WIDTH)) u_slot (
            .clk      (clk),
            .reset    (reset),
            .hold     (hold[i]),
            .load     (src_valid[i]),
            .src_data (src_data[i*WIDTH +: WIDTH]),
            .kill     (kill[i]),
            .valid    (stage_valid[i]),
            .data     (stage_data[i*WIDTH +: WIDTH])
        );
    end

    assign in_ready  = ~hold[0];
    assign out_valid = stage_valid[STAGES-1];
    assign out_data  = stage_data[(STAGES-1)*WIDTH +: WIDTH];
endmodule

// File: tb/tb_pipe_chain.sv
// tb_pipe_chain: random and directed checks of both chain modes against a slot-origin model
module tb_pipe_chain;
    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, out_ready;
    logic [31:0]  in_data;
    logic [3:0]   stall_req, flush_req;
    logic         rdy_c, ov_c, rdy_l, ov_l;
    logic [31:0]  od_c, od_l;
    logic [3:0]   sv_c, sv_l;
    logic [127:0] sd_c, sd_l;
    logic [2:0]   cnt_c, cnt_l;

    int errors = 0;
    int checks = 0;

    // model state: index 0 = collapse DUT, index 1 = lockstep DUT
    bit          mv [2][4];
    logic [31:0] md [2][4];
    bit          nv [2][4];
    logic [31:0] nd [2][4];
    bit          exp_rdy [2];

    always #5 clk = ~clk;

    pipe_chain #(.WIDTH(32), .STAGES(4), .BUBBLE_COLLAPSE(1)) dut_c (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_c),
        .stall_req(stall_req), .flush_req(flush_req), .out_valid(ov_c), .out_data(od_c),
        .out_ready(out_ready), .stage_valid(sv_c), .stage_data(sd_c), .count(cnt_c)
    );

    pipe_chain #(.WIDTH(32), .STAGES(4), .BUBBLE_COLLAPSE(0)) dut_l (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_l),
        .stall_req(stall_req), .flush_req(flush_req), .out_valid(ov_l), .out_data(od_l),
        .out_ready(out_ready), .stage_valid(sv_l), .stage_data(sd_l), .count(cnt_l)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 4; k++) begin
                mv[d][k] = 1'b0;
                md[d][k] = '0;
            end
    endtask

    // each slot's next content is tagged with the slot it came from (-1 = input); a flush at f kills origins <= f
    task automatic model_eval(input int d);
        bit blk [4];
        int f, org;
        f = -1;
        for (int k = 0; k < 4; k++) if (flush_req[k]) f = k;
        blk[3] = stall_req[3] | (mv[d][3] & ~out_ready);
        for (int k = 2; k >= 0; k--) blk[k] = stall_req[k] | ((d == 1 || mv[d][k]) & blk[k+1]);
        for (int k = 0; k < 4; k++) begin
            nd[d][k] = md[d][k];
            if (blk[k]) begin
                nv[d][k] = mv[d][k];
                org = k;
            end else if (k == 0) begin
                nv[d][k] = in_valid;
                if (in_valid) nd[d][k] = in_data;
                org = -1;
            end else begin
                nv[d][k] = mv[d][k-1] & ~blk[k-1];
                if (nv[d][k]) nd[d][k] = md[d][k-1];
                org = k - 1;
            end
            if (f >= 0 && org <= f) nv[d][k] = 1'b0;
        end
        exp_rdy[d] = ~blk[0];
    endtask

    task automatic check_dut(input int d);
        logic [3:0]   gv, ev;
        logic [127:0] gd;
        int           n;
        gv = d == 0 ? sv_c : sv_l;
        gd = d == 0 ? sd_c : sd_l;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            ev[k] = mv[d][k];
            n += int'(mv[d][k]);
        end
        chk($sformatf("d%0d stage_valid", d), gv, ev);
        chk($sformatf("d%0d count", d), d == 0 ? cnt_c : cnt_l, n);
        chk($sformatf("d%0d out_valid", d), d == 0 ? ov_c : ov_l, ev[3]);
        chk($sformatf("d%0d in_ready", d), d == 0 ? rdy_c : rdy_l, exp_rdy[d]);
        for (int k = 0; k < 4; k++)
            if (mv[d][k]) chk($sformatf("d%0d slot%0d data", d, k), gd[k*32 +: 32], md[d][k]);
    endtask

    // inputs are applied just after a rising edge; compare at the falling edge, then advance the model
    task automatic step();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            model_eval(d);
            check_dut(d);
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 4; k++) begin
                mv[d][k] = nv[d][k];
                md[d][k] = nd[d][k];
            end
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1; stall_req = '0; flush_req = '0;
    endtask

    task automatic fill(input logic [31:0] base);
        idle();
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = base + 32'(i);
            step();
        end
        idle();
    endtask

    initial begin
        idle();
        model_clear();
        reset = 1'b0;
        #2;
        chk("reset valid_c", sv_c, 4'b0);
        chk("reset count_l", cnt_l, 3'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // streaming: first item reaches the output after the 4th edge
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 32'(i + 1);
            step();
            if (i == 3) begin
                chk("stream first out", od_c, 32'h1);
                chk("stream out_valid", ov_c, 1'b1);
            end
        end
        chk("stream count", cnt_c, 3'd4);
        chk("stream in_ready", rdy_c, 1'b1);
        chk("stream out seq", od_l, 32'h5);

        // lockstep stall on slot 2
        fill(32'hA0);
        stall_req = 4'b0100;
        #1;
        chk("lstall in_ready", rdy_l, 1'b0);
        step();
        chk("lstall valid", sv_l, 4'b0111);
        chk("lstall count", cnt_l, 3'd3);
        chk("lstall s2 data", sd_l[64 +: 32], 32'hA1);
        idle();

        // empty both pipes, then build A,_,B,C with the output blocked
        flush_req = 4'b1000;
        step();
        idle();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hC1; step();
        in_valid = 1'b0; step();
        in_valid = 1'b1; in_data = 32'hC2; step();
        in_data = 32'hC3; step();
        chk("gap valid_c", sv_c, 4'b1011);
        chk("gap valid_l", sv_l, 4'b1011);
        in_data = 32'hCE;
        #1;
        chk("collapse in_ready_c", rdy_c, 1'b1);
        chk("collapse in_ready_l", rdy_l, 1'b0);
        step();
        chk("collapse valid_c", sv_c, 4'b1111);
        chk("collapse count_c", cnt_c, 3'd4);
        chk("collapse data_c", sd_c, {32'hC1, 32'hC2, 32'hC3, 32'hCE});
        chk("lockstep frozen", sv_l, 4'b1011);
        chk("lockstep data", sd_l[31:0], 32'hC3);

        // flush addressed at slot 1 with a new input pending
        fill(32'hD0);
        in_valid = 1'b1; in_data = 32'hDE; flush_req = 4'b0010;
        step();
        chk("flush valid_c", sv_c, 4'b1000);
        chk("flush valid_l", sv_l, 4'b1000);
        chk("flush count", cnt_c, 3'd1);
        chk("flush s3 data", od_c, 32'hD1);

        // stall and flush on the same slot
        fill(32'hF0);
        stall_req = 4'b0010; flush_req = 4'b0010;
        step();
        chk("sf valid_c", sv_c, 4'b1000);
        chk("sf valid_l", sv_l, 4'b1000);
        chk("sf s1 data", sd_c[32 +: 32], 32'hF2);
        chk("sf s3 data", od_l, 32'hF1);
        idle();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            in_data   = $urandom;
            out_ready = $urandom_range(0, 3) != 0;
            stall_req = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0;
            flush_req = ($urandom_range(0, 11) == 0) ? 4'($urandom) : 4'b0;
            step();
        end

        // asynchronous reset mid-cycle while full
        fill(32'h50);
        chk("pre-reset count", cnt_c, 3'd4);
        #2;
        reset = 1'b0;
        #1;
        chk("areset valid_c", sv_c, 4'b0);
        chk("areset valid_l", sv_l, 4'b0);
        chk("areset out_valid", ov_c, 1'b0);
        chk("areset count", cnt_l, 3'd0);
        model_clear();
        reset = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 32'h60 + 32'(i);
            step();
        end
        chk("post-reset latency", od_c, 32'h60);
        chk("post-reset valid", ov_l, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
